// File: rtl/uart_alu_interface_if.sv
// Bus between the UART/ALU command sequencer and its environment: receiver bytes,
// ALU operand/result lines and the transmitter start/done handshake.
interface uart_alu_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_overrun;
    logic               o_timeout;

    // Sequencer side
    modport master (
        input  i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_overrun, o_timeout
    );

    // Receiver / ALU / transmitter side
    modport slave (
        output i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_overrun, o_timeout
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, feeds the ALU and
// hands its result to the transmitter. Optional inter-byte timeout: UART_ALU_IF_TIMEOUT_EN.
module uart_alu_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    uart_alu_interface_if.master bus
);
    localparam logic [5:0] ST_WAIT_A   = 6'b000001;
    localparam logic [5:0] ST_WAIT_B   = 6'b000010;
    localparam logic [5:0] ST_WAIT_OP  = 6'b000100;
    localparam logic [5:0] ST_EXEC     = 6'b001000;
    localparam logic [5:0] ST_TX_START = 6'b010000;
    localparam logic [5:0] ST_TX_WAIT  = 6'b100000;

    logic [5:0]         state_q,    state_d;
    logic [NB_DATA-1:0] alu_a_q,    alu_a_d;
    logic [NB_DATA-1:0] alu_b_q,    alu_b_d;
    logic [NB_OP-1:0]   alu_op_q,   alu_op_d;
    logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               overrun_q,  overrun_d;
    logic               busy_s;
    logic               expire_s;

    assign busy_s = (state_q == ST_EXEC) || (state_q == ST_TX_START) || (state_q == ST_TX_WAIT);

`ifdef UART_ALU_IF_TIMEOUT_EN
    localparam int NB_CNT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              in_wait_s;

    assign in_wait_s = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    // A byte on the terminal count wins over the timeout
    assign expire_s  = in_wait_s && !bus.i_rx_valid && (cnt_q == CNT_LAST);
    assign timeout_d = expire_s;

    // Inter-byte counter: runs only while waiting for B or the opcode, otherwise held at zero
    always_comb begin
        if (in_wait_s && !bus.i_rx_valid && !expire_s) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end else begin
            cnt_d = {NB_CNT{1'b0}};
        end
    end

    // Counter and timeout pulse registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q     <= {NB_CNT{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT_CYCLES == 32'sd0);
    assign expire_s         = 1'b0;
    assign bus.o_timeout    = 1'b0;
`endif

    // Next-state and datapath capture; any non-one-hot state falls back to WAIT_A
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = overrun_q | (busy_s & bus.i_rx_valid);
        case (state_q)
            ST_WAIT_A: begin
                if (bus.i_rx_valid) begin
                    alu_a_d = bus.i_rx_data;
                    state_d = ST_WAIT_B;
                end else begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (bus.i_rx_valid) begin
                    alu_b_d = bus.i_rx_data;
                    state_d = ST_WAIT_OP;
                end else if (expire_s) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (bus.i_rx_valid) begin
                    alu_op_d = bus.i_rx_data[NB_OP-1:0];
                    state_d  = ST_EXEC;
                end else if (expire_s) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                // Start is registered here so it is high exactly during TX_START
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                state_d    = ST_TX_START;
            end
            ST_TX_START: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (bus.i_tx_done) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_WAIT_A;
            alu_a_q    <= {NB_DATA{1'b0}};
            alu_b_q    <= {NB_DATA{1'b0}};
            alu_op_q   <= {NB_OP{1'b0}};
            tx_data_q  <= {NB_DATA{1'b0}};
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_alu_a    = alu_a_q;
    assign bus.o_alu_b    = alu_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_overrun  = overrun_q;
endmodule
